// File: rtl/nibble_packer.sv
// Packs consecutive 4-bit samples (LSB nibble first) into words and queues them in a small FIFO.
// Optional NIBBLE_PACKER_CHECK_EN builds a true/complement cross-check that drives the sticky o_err.
module nibble_packer #(
    parameter int NIBBLES = 4,
    parameter int DEPTH   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [3:0]             i_a,
    input  logic [3:0]             i_b,
    input  logic                   i_clr,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [4*NIBBLES-1:0]   o_data,
    output logic [2:0]             o_count,
    output logic                   o_full,
    output logic                   o_ovf,
    output logic                   o_err
);

    localparam int         W     = 4 * NIBBLES;
    localparam int         PTR_W = $clog2(DEPTH);
    localparam int         CNT_W = PTR_W + 1;
    localparam logic [2:0] LAST  = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {EMPTY, FILL, COMPLETE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         idx;
    logic [W-1:0]       shreg;
    logic [W-1:0]       word;
    logic [W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic               accept;
    logic               push_req;
    logic               pop;
    logic               push;
    logic               drop;

    // A clear on the same edge as a sample wins; that sample is discarded.
    assign accept = i_en && !i_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clr) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = (idx == LAST) ? COMPLETE : FILL;
        end else if (state_q == COMPLETE) begin
            state_d = EMPTY;
        end
    end

    // The final nibble always lands while in FILL because NIBBLES is at least 2.
    always_comb begin
        push_req = accept && (state_q == FILL) && (idx == LAST);
        pop      = o_valid && i_ready;
        push     = push_req && (!o_full || pop);
        drop     = push_req && !push;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx   <= '0;
            shreg <= '0;
        end else if (i_clr) begin
            idx <= '0;
        end else if (accept) begin
            shreg[4*idx +: 4] <= i_a;
            idx               <= (idx == LAST) ? 3'd0 : idx + 3'd1;
        end
    end

    // Completed word is the held partial with the final nibble merged in this cycle.
    always_comb begin
        word              = shreg;
        word[4*idx +: 4]  = i_a;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
        end else if (i_clr) begin
            o_ovf <= 1'b0;
        end else if (drop) begin
            o_ovf <= 1'b1;
        end
    end

`ifdef NIBBLE_PACKER_CHECK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (i_clr) begin
            o_err <= 1'b0;
        end else if (accept && (i_a != ~i_b)) begin
            o_err <= 1'b1;
        end
    end
`else
    logic unused_b;
    assign unused_b = ^i_b;
    assign o_err    = 1'b0;
`endif

    assign o_valid = (occ != '0);
    assign o_full  = (occ == CNT_W'(DEPTH));
    assign o_data  = mem[rd_ptr];
    assign o_count = idx;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_nibble_packer;

    localparam int NIB = 4;
    localparam int DEP = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [3:0]  i_a;
    logic [3:0]  i_b;
    logic        i_clr;
    logic        i_ready;
    logic        o_valid;
    logic [15:0] o_data;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_ovf;
    logic        o_err;

    nibble_packer #(.NIBBLES(NIB), .DEPTH(DEP)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_clr   (i_clr),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_count (o_count),
        .o_full  (o_full),
        .o_ovf   (o_ovf),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mq[$];
    logic [3:0]  part[$];
    logic        m_ovf;
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        part.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        bit          pop;
        bit          room;
        logic [15:0] w;
        pop  = (mq.size() > 0) && i_ready;
        room = (mq.size() < DEP) || pop;
        if (pop) void'(mq.pop_front());
        if (i_clr) begin
            part.delete();
            m_ovf = 1'b0;
            m_err = 1'b0;
        end else if (i_en) begin
`ifdef NIBBLE_PACKER_CHECK_EN
            if (i_a != ~i_b) m_err = 1'b1;
`endif
            part.push_back(i_a);
            if (part.size() == NIB) begin
                w = '0;
                foreach (part[k]) w = w + (16'(part[k]) << (4 * k));
                if (room) mq.push_back(w);
                else      m_ovf = 1'b1;
                part.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("valid", 32'(o_valid), 32'(mq.size() > 0));
        chk("count", 32'(o_count), 32'(part.size()));
        chk("full",  32'(o_full),  32'(mq.size() == DEP));
        chk("ovf",   32'(o_ovf),   32'(m_ovf));
        chk("err",   32'(o_err),   32'(m_err));
        if (mq.size() > 0) chk("data", 32'(o_data), 32'(mq[0]));
    endtask

    // Called at a falling edge; drives, lets one rising edge pass, then checks.
    task automatic cyc(input logic en, input logic [3:0] a, input logic [3:0] b,
                       input logic clr, input logic rdy);
        i_en = en; i_a = a; i_b = b; i_clr = clr; i_ready = rdy;
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic smp(input logic [3:0] a, input logic rdy);
        cyc(1'b1, a, ~a, 1'b0, rdy);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 4'h0, 4'hF, 1'b0, rdy);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(o_valid), 32'd0);
        chk({nm, "_data"},  32'(o_data),  32'd0);
        chk({nm, "_count"}, 32'(o_count), 32'd0);
        chk({nm, "_full"},  32'(o_full),  32'd0);
        chk({nm, "_ovf"},   32'(o_ovf),   32'd0);
        chk({nm, "_err"},   32'(o_err),   32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_a = 4'h0; i_b = 4'hF; i_clr = 1'b0; i_ready = 1'b0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        chk_zero("rst");
        i_rst = 1'b0;
        compare_all();

        // Basic pack
        smp(4'h1, 1'b1); chk("basic_cnt1", 32'(o_count), 32'd1);
        smp(4'h2, 1'b1); chk("basic_cnt2", 32'(o_count), 32'd2);
        smp(4'h3, 1'b1); chk("basic_cnt3", 32'(o_count), 32'd3);
        smp(4'h4, 1'b1);
        chk("basic_cnt0",  32'(o_count), 32'd0);
        chk("basic_valid", 32'(o_valid), 32'd1);
        chk("basic_data",  32'(o_data),  32'h4321);
        idle(1'b1);
        chk("basic_drain", 32'(o_valid), 32'd0);

        // Backpressure and overflow
        for (int i = 1; i <= 12; i++) begin
            smp(4'(i), 1'b0);
            if (i == 8) chk("bp_full", 32'(o_full), 32'd1);
        end
        chk("bp_ovf",   32'(o_ovf),  32'd1);
        chk("bp_head1", 32'(o_data), 32'h4321);
        idle(1'b1);
        chk("bp_head2", 32'(o_data), 32'h8765);
        idle(1'b1);
        chk("bp_empty", 32'(o_valid), 32'd0);
        cyc(1'b0, 4'h0, 4'hF, 1'b1, 1'b1);
        chk("bp_clr_ovf", 32'(o_ovf), 32'd0);

        // Push and pop on the same edge while full
        for (int i = 1; i <= 8; i++) smp(4'(i), 1'b0);
        smp(4'h9, 1'b0); smp(4'hA, 1'b0); smp(4'hB, 1'b0);
        smp(4'hC, 1'b1);
        chk("pp_ovf",   32'(o_ovf),  32'd0);
        chk("pp_full",  32'(o_full), 32'd1);
        chk("pp_head",  32'(o_data), 32'h8765);
        idle(1'b1);
        chk("pp_word3", 32'(o_data), 32'hCBA9);
        idle(1'b1);
        chk("pp_empty", 32'(o_valid), 32'd0);

        // Asynchronous reset mid-word with a word queued
        for (int i = 1; i <= 4; i++) smp(4'(i), 1'b0);
        smp(4'h7, 1'b0); smp(4'h7, 1'b0);
        chk("mr_count_pre", 32'(o_count), 32'd2);
        #2 i_rst = 1'b1;
        #1 chk_zero("mr");
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        compare_all();
        smp(4'h9, 1'b1); smp(4'hA, 1'b1); smp(4'hB, 1'b1); smp(4'hC, 1'b1);
        chk("mr_data", 32'(o_data), 32'hCBA9);
        idle(1'b1);

        // Complement cross-check
        cyc(1'b1, 4'h5, 4'hA, 1'b0, 1'b1);
        chk("ck_match", 32'(o_err), 32'd0);
        cyc(1'b1, 4'h5, 4'hB, 1'b0, 1'b1);
`ifdef NIBBLE_PACKER_CHECK_EN
        chk("ck_mismatch", 32'(o_err), 32'd1);
`else
        chk("ck_mismatch", 32'(o_err), 32'd0);
`endif
        cyc(1'b0, 4'h0, 4'hF, 1'b1, 1'b1);
        chk("ck_clr",   32'(o_err),   32'd0);
        chk("ck_count", 32'(o_count), 32'd0);

        // Clear beats a same-edge sample
        smp(4'h1, 1'b1); smp(4'h2, 1'b1);
        cyc(1'b1, 4'h3, 4'hC, 1'b1, 1'b1);
        chk("cp_count", 32'(o_count), 32'd0);
        smp(4'h4, 1'b1); smp(4'h5, 1'b1); smp(4'h6, 1'b1); smp(4'h7, 1'b1);
        chk("cp_data", 32'(o_data), 32'h7654);
        idle(1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
